quad_nand_exerciser: RTL

Self-checking stimulus/response stage for the quad 2-input NAND emulator. On START it sweeps all 256 combinations of the NAND IC's eight inputs (A, B, C, D, two bits each) and samples the IC's 4-bit Y output after a programmable settle time. It compares each sample against the ideal NAND truth table, counts failing vectors and reports pass/fail. It sits directly around the NAND IC: its outputs feed the IC inputs, and it consumes the IC outputs.

---
 rtl/quad_nand_exerciser_if.sv | 30 +++
 rtl/quad_nand_exerciser.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/quad_nand_exerciser_if.sv
// Stimulus/response bundle between the NAND exerciser and its environment.
// The exerciser takes the slave modport; the driving side takes master.
interface quad_nand_exerciser_if #(
  parameter int unsigned ERR_W = 9
);
  logic             start;
  logic             abort;
  logic [3:0]       y_in;
  logic [1:0]       a;
  logic [1:0]       b;
  logic [1:0]       c;
  logic [1:0]       d;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [7:0]       fail_pat;
  logic [3:0]       fail_y;

  modport slave (
    input  start, abort, y_in,
    output a, b, c, d, busy, done, pass, err_cnt, fail_valid, fail_pat, fail_y
  );

  modport master (
    output start, abort, y_in,
    input  a, b, c, d, busy, done, pass, err_cnt, fail_valid, fail_pat, fail_y
  );
endinterface

// File: rtl/quad_nand_exerciser.sv
// Sweeps all 256 input vectors of a quad 2-input NAND and checks Y against the ideal truth table.
// Optional first-failure record: define QUAD_NAND_EXERCISER_FAIL_LOG_EN.
module quad_nand_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 9
) (
  input logic                   clk,
  input logic                   rst_n,
  quad_nand_exerciser_if.slave  bus
);

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [PAT_W-1:0] PAT_LAST    = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat, pat_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ERR_W-1:0] err, err_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic             pass, pass_nxt;
  logic [3:0]       exp_c;
  logic             sample_c;
  logic             miss_c;

  assign exp_c    = {~&pat[7:6], ~&pat[5:4], ~&pat[3:2], ~&pat[1:0]};
  assign sample_c = (cnt == SETTLE_LAST);
  assign miss_c   = (bus.y_in != exp_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pat   <= '0;
      cnt   <= '0;
      err   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_nxt;
      pat   <= pat_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      pass  <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    cnt_nxt   = cnt;
    err_nxt   = err;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_nxt = ST_RUN;
          pat_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = '0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          // partial error count is kept for inspection after an abort
          state_nxt = ST_IDLE;
          pat_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
        end else if (sample_c) begin
          cnt_nxt = '0;
          pat_nxt = pat + PAT_W'(1);
          if (miss_c) err_nxt = err + ERR_W'(1);
          if (pat == PAT_LAST) begin
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == '0);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // pattern counter wraps to 0 after vector 255, so A..D idle at 0 in DONE
  assign bus.a       = pat[1:0];
  assign bus.b       = pat[3:2];
  assign bus.c       = pat[5:4];
  assign bus.d       = pat[7:6];
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.pass    = pass;
  assign bus.err_cnt = err;

`ifdef QUAD_NAND_EXERCISER_FAIL_LOG_EN
  logic       fail_valid;
  logic [7:0] fail_pat;
  logic [3:0] fail_y;
  logic       launch_c;
  logic       capture_c;

  assign launch_c  = (state != ST_RUN) && bus.start;
  assign capture_c = (state == ST_RUN) && !bus.abort && sample_c && miss_c && !fail_valid;

  // first mismatch of a sweep is latched; later ones leave the record alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_pat   <= '0;
      fail_y     <= '0;
    end else if (launch_c) begin
      fail_valid <= 1'b0;
      fail_pat   <= '0;
      fail_y     <= '0;
    end else if (capture_c) begin
      fail_valid <= 1'b1;
      fail_pat   <= pat;
      fail_y     <= bus.y_in;
    end
  end

  assign bus.fail_valid = fail_valid;
  assign bus.fail_pat   = fail_pat;
  assign bus.fail_y     = fail_y;
`else
  assign bus.fail_valid = 1'b0;
  assign bus.fail_pat   = '0;
  assign bus.fail_y     = '0;
`endif

endmodule
